ssd_capture: RTL and testbench
==============================

Name: ssd_capture

Overview:
- Receive-side counterpart of the multiplexed 8-digit seven-segment driver.
- Watches the scanned anode/segment bus and waits for each digit slot to settle.
- Decodes the segment patterns back to digits and rebuilds the 4-digit decimal number plus the score digit.
- Used as an in-fabric display monitor, as a self-check against the game's number/score registers, and as the bench scoreboard for the display path.

Parameters:
- SETTLE_CYCLES, 16: consecutive cycles {anode_in, ssd_in} must hold unchanged before a slot is sampled; legal range 2..65535.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- anode_in  in  8  anode bus, active-low one-hot; bit0 = thousands, bit1 = hundreds, bit2 = tens, bit3 = units, bit4 = score, bits5-7 unused.
- ssd_in  in  7  segment bus {a,b,c,d,e,f,g}, active-low.
- number  out  16  binary value of the last complete frame.
- score  out  3  score digit of the last complete frame.
- blank_mask  out  5  per-slot flag: slot was blank (1111111) in the last frame.
- frame_valid  out  1  one-cycle pulse when number/score/blank_mask update.
- digit_err  out  1  one-cycle pulse on an illegal pattern or an out-of-range score.
- bus_err  out  1  one-cycle pulse on an anode value with more than one low bit.

Behaviour:
- Reset values:
  - number = 0, score = 0, blank_mask = 5'b11111.
  - frame_valid, digit_err, bus_err = 0.
  - Internal: seen mask = 0, stable counter = 0, captured flag = 0, input register = all ones.
- Input stage: anode_in and ssd_in are registered once; all logic below runs on the registered copy.
- Settle counter:
  - Clears to 0 on any cycle where the registered {anode, ssd} differs from the previous cycle.
  - Otherwise increments and saturates at SETTLE_CYCLES-1.
  - A change also clears the captured flag.
- Capture condition: counter == SETTLE_CYCLES-1, captured flag == 0, and anode has exactly one low bit among bits 0-4.
  - On capture, set the captured flag. Exactly one capture occurs per dwell, however long the dwell lasts.
- Ignored anode values:
  - All-ones anode, or a single low bit in 5-7: no capture, no error.
  - Two or more low bits, once settled: pulse bus_err once per dwell and do not capture.
- Decode table:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100.
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
  - 1111111 = blank: value 0, blank bit set.
  - Any other pattern: pulse digit_err, clear the seen mask, abandon the frame.
- Score slot: a decoded value of 8 or 9 on slot 4 is a digit_err, with the same abandon rule.
- Frame assembly:
  - A slot 0 capture clears the seen mask, then records digit 0.
  - A slot 1-3 capture records its digit and sets its seen bit.
  - A slot 4 capture with seen[3:0] = 1111 completes the frame. With seen[3:0] incomplete, it clears the mask and produces no frame.
  - A repeated slot overwrites its digit.
- Output update:
  - On frame completion, compute number = d0*1000 + d1*100 + d2*10 + d3. Each multiply is a shift-add; the result fits in 14 bits and is zero-extended to 16.
  - number, score and blank_mask register 1 cycle after the slot-4 capture, with frame_valid high in that same cycle.
  - Outputs hold until the next frame.
- Simultaneous events: bus_err and digit_err are mutually exclusive by construction. frame_valid can coincide with nothing else, since only one capture occurs per cycle.
- Reset mid-frame: all state returns to reset values immediately. The first frame after reset requires a fresh slot 0 dwell.

Optional Feature:
- Macro: SSD_CAPTURE_STATS_EN.
- Defined:
  - Adds output frame_count (16 bits, reset 0). It increments on each frame_valid and wraps 0xFFFF -> 0x0000.
  - Adds output err_count (8 bits, reset 0). It increments on each digit_err or bus_err and saturates at 0xFF.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- Scan slots 0-4 at 40 cycles per dwell showing "1234" and score 5 -> frame_valid pulses once, 1 cycle after the slot-4 capture; number = 16'd1234, score = 3'd5, blank_mask = 0.
- Show "9876" with score 7 (exercises 8/9 decode) -> number = 16'd9876, score = 7; then show "0000" with slot 2 blank -> number = 0, blank_mask = 5'b00100.
- Dwell of 10 cycles with SETTLE_CYCLES = 16 -> no capture and no frame_valid; a single 60-cycle dwell -> exactly one capture.
- Slot 1 showing 1111110, or slot 4 showing digit 8 -> one digit_err pulse, no frame for that scan; the next clean scan produces a frame.
- anode = 8'b11111100 held 40 cycles -> one bus_err pulse, no capture; scan order 0,1,3,4 (slot 2 skipped) -> no frame_valid.
- Assert rst_n low mid-scan after slot 2 -> all outputs at reset values; resuming at slot 3 gives no frame until a full 0-4 scan completes. With SSD_CAPTURE_STATS_EN defined, frame_count = 1 after that scan.

Source files
------------

// File: rtl/ssd_capture.sv
// ssd_capture: rebuilds number/score frames from a scanned 8-digit seven-segment bus (optional stats via SSD_CAPTURE_STATS_EN).
module ssd_capture #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  anode_in,
  input  logic [6:0]  ssd_in,
  output logic [15:0] number,
  output logic [2:0]  score,
  output logic [4:0]  blank_mask,
  output logic        frame_valid,
  output logic        digit_err,
  output logic        bus_err
`ifdef SSD_CAPTURE_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
`endif
);
  localparam logic [15:0] LAST = 16'(SETTLE_CYCLES - 1);
  logic [7:0] a_r, a_p;
  logic [6:0] s_r, s_p;
  logic [15:0] cnt;
  logic captured;
  logic [3:0] seen, bl;
  logic [3:0][3:0] dig;
  logic chg, settle, one_low, multi, bad, take, frame_fire, err_fire;
  logic [3:0] n_low;
  logic [2:0] slot;
  logic [5:0] dec;
  logic [13:0] num_nx;
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 6'd0;
      7'b1001111: decode = 6'd1;
      7'b0010010: decode = 6'd2;
      7'b0000110: decode = 6'd3;
      7'b1001100: decode = 6'd4;
      7'b0100100: decode = 6'd5;
      7'b0100000: decode = 6'd6;
      7'b0001111: decode = 6'd7;
      7'b0000000: decode = 6'd8;
      7'b0000100: decode = 6'd9;
      7'b1111111: decode = 6'b010000;
      default:    decode = 6'b100000;
    endcase
  endfunction
  function automatic logic [13:0] m1000(input logic [3:0] v);
    logic [13:0] x;
    x = 14'(v);
    return (x << 9) + (x << 8) + (x << 7) + (x << 6) + (x << 5) + (x << 3);
  endfunction
  function automatic logic [13:0] m100(input logic [3:0] v);
    logic [13:0] x;
    x = 14'(v);
    return (x << 6) + (x << 5) + (x << 2);
  endfunction
  function automatic logic [13:0] m10(input logic [3:0] v);
    logic [13:0] x;
    x = 14'(v);
    return (x << 3) + (x << 1);
  endfunction
  always_comb begin
    chg = {a_r, s_r} != {a_p, s_p};
    settle = !chg && cnt == LAST && !captured;
    n_low = 4'($countones(~a_r));
    one_low = n_low == 4'd1 && &a_r[7:5];
    multi = n_low > 4'd1;
    slot = !a_r[0] ? 3'd0 : !a_r[1] ? 3'd1 : !a_r[2] ? 3'd2 : !a_r[3] ? 3'd3 : 3'd4;
    dec = decode(s_r);
    bad = dec[5] || (slot == 3'd4 && dec[3:0] > 4'd7);
    take = settle && one_low;
    frame_fire = take && !bad && slot == 3'd4 && &seen;
    err_fire = settle && (multi || (one_low && bad));
    num_nx = m1000(dig[0]) + m100(dig[1]) + m10(dig[2]) + 14'(dig[3]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '1;
      a_p <= '1;
      s_r <= '1;
      s_p <= '1;
      cnt <= '0;
      captured <= 1'b0;
      seen <= '0;
      bl <= '0;
      dig <= '0;
      number <= '0;
      score <= '0;
      blank_mask <= '1;
      frame_valid <= 1'b0;
      digit_err <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      a_r <= anode_in;
      s_r <= ssd_in;
      a_p <= a_r;
      s_p <= s_r;
      cnt <= chg ? '0 : cnt == LAST ? cnt : cnt + 16'd1;
      captured <= chg ? 1'b0 : captured | settle;
      frame_valid <= frame_fire;
      digit_err <= take && bad;
      bus_err <= settle && multi;
      if (frame_fire) begin
        number <= {2'b00, num_nx};
        score <= dec[2:0];
        blank_mask <= {dec[4], bl};
      end
      // bad patterns and incomplete score-slot arrivals both abandon the frame
      if (take && (bad || (slot == 3'd4 && !(&seen))))
        seen <= '0;
      else if (take && slot != 3'd4) begin
        dig[slot[1:0]] <= dec[3:0];
        bl[slot[1:0]] <= dec[4];
        seen <= slot == 3'd0 ? 4'b0001 : seen | (4'b0001 << slot[1:0]);
      end
    end
`ifdef SSD_CAPTURE_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_count <= '0;
      err_count <= '0;
    end else begin
      frame_count <= frame_count + 16'(frame_fire);
      err_count <= err_count + 8'(err_fire && err_count != 8'hff);
    end
`endif
endmodule

// File: tb/tb_ssd_capture.sv
// tb_ssd_capture: directed scans of the display bus with hand-computed frames and error pulses.
module tb_ssd_capture;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] anode_in;
  logic [6:0] ssd_in;
  logic [15:0] number;
  logic [2:0] score;
  logic [4:0] blank_mask;
  logic frame_valid, digit_err, bus_err;
`ifdef SSD_CAPTURE_STATS_EN
  logic [15:0] frame_count;
  logic [7:0] err_count;
`endif
  int cyc = 0, nfv = 0, nde = 0, nbe = 0, fv_cyc = 0, s4 = 0;
  int b_fv, b_de, b_be;
  int total = 0, bad = 0;
  ssd_capture dut (
    .clk(clk), .rst_n(rst_n), .anode_in(anode_in), .ssd_in(ssd_in),
    .number(number), .score(score), .blank_mask(blank_mask),
    .frame_valid(frame_valid), .digit_err(digit_err), .bus_err(bus_err)
`ifdef SSD_CAPTURE_STATS_EN
    , .frame_count(frame_count), .err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (frame_valid) begin
      nfv = nfv + 1;
      fv_cyc = cyc;
    end
    if (digit_err) nde = nde + 1;
    if (bus_err) nbe = nbe + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b0000001;
      1: seg = 7'b1001111;
      2: seg = 7'b0010010;
      3: seg = 7'b0000110;
      4: seg = 7'b1001100;
      5: seg = 7'b0100100;
      6: seg = 7'b0100000;
      7: seg = 7'b0001111;
      8: seg = 7'b0000000;
      default: seg = 7'b0000100;
    endcase
  endfunction
  task automatic drive(input logic [7:0] a, input logic [6:0] p, input int n);
    anode_in = a;
    ssd_in = p;
    repeat (n) @(negedge clk);
  endtask
  task automatic show(input int s, input logic [6:0] p, input int n);
    if (s == 4) s4 = cyc;
    drive(~(8'd1 << s), p, n);
  endtask
  task automatic scan(input int d0, input int d1, input int d2, input int d3, input int d4);
    show(0, seg(d0), 40);
    show(1, seg(d1), 40);
    show(2, seg(d2), 40);
    show(3, seg(d3), 40);
    show(4, seg(d4), 40);
  endtask
  task automatic mark;
    b_fv = nfv;
    b_de = nde;
    b_be = nbe;
  endtask
  initial begin
    rst_n = 1'b0;
    anode_in = 8'hff;
    ssd_in = 7'h7f;
    repeat (3) @(negedge clk);
    check("rst_number", number, 0);
    check("rst_score", score, 0);
    check("rst_blank", blank_mask, 5'b11111);
    check("rst_fv", frame_valid, 0);
    check("rst_derr", digit_err, 0);
    check("rst_berr", bus_err, 0);
    rst_n = 1'b1;
    mark;
    scan(1, 2, 3, 4, 5);
    check("f1234_count", nfv - b_fv, 1);
    check("f1234_latency", fv_cyc - s4, 18);
    check("f1234_number", number, 1234);
    check("f1234_score", score, 5);
    check("f1234_blank", blank_mask, 0);
    mark;
    scan(9, 8, 7, 6, 7);
    check("f9876_count", nfv - b_fv, 1);
    check("f9876_number", number, 9876);
    check("f9876_score", score, 7);
    mark;
    show(0, seg(0), 40);
    show(1, seg(0), 40);
    show(2, 7'h7f, 40);
    show(3, seg(0), 40);
    show(4, seg(0), 40);
    check("blank_count", nfv - b_fv, 1);
    check("blank_number", number, 0);
    check("blank_mask", blank_mask, 5'b00100);
    mark;
    show(0, seg(1), 40);
    show(1, seg(2), 10);
    show(2, seg(3), 40);
    show(3, seg(4), 40);
    show(4, seg(5), 40);
    check("short_dwell_nofv", nfv - b_fv, 0);
    check("short_dwell_num", number, 0);
    mark;
    show(0, seg(5), 40);
    show(1, seg(6), 40);
    show(2, seg(7), 40);
    show(3, seg(8), 40);
    show(4, seg(3), 60);
    check("long_dwell_count", nfv - b_fv, 1);
    check("long_dwell_number", number, 5678);
    check("long_dwell_score", score, 3);
    mark;
    show(0, seg(1), 40);
    show(1, 7'b1111110, 40);
    show(2, seg(3), 40);
    show(3, seg(4), 40);
    show(4, seg(5), 40);
    check("badseg_derr", nde - b_de, 1);
    check("badseg_nofv", nfv - b_fv, 0);
    check("badseg_hold", number, 5678);
    mark;
    scan(2, 4, 6, 8, 1);
    check("recover_count", nfv - b_fv, 1);
    check("recover_number", number, 2468);
    mark;
    scan(1, 1, 1, 1, 8);
    check("score8_derr", nde - b_de, 1);
    check("score8_nofv", nfv - b_fv, 0);
    check("score8_hold", score, 1);
    mark;
    drive(8'b11111100, seg(3), 40);
    check("multi_berr", nbe - b_be, 1);
    check("multi_derr", nde - b_de, 0);
    check("multi_nofv", nfv - b_fv, 0);
    show(0, seg(1), 40);
    show(1, seg(2), 40);
    show(3, seg(3), 40);
    show(4, seg(4), 40);
    check("skip2_nofv", nfv - b_fv, 0);
    check("skip2_hold", number, 2468);
    show(0, seg(3), 40);
    show(1, seg(2), 40);
    show(2, seg(1), 40);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_number", number, 0);
    check("midrst_score", score, 0);
    check("midrst_blank", blank_mask, 5'b11111);
    check("midrst_fv", frame_valid, 0);
`ifdef SSD_CAPTURE_STATS_EN
    check("midrst_fcount", frame_count, 0);
    check("midrst_ecount", err_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    mark;
    show(3, seg(4), 40);
    show(4, seg(6), 40);
    check("resume_nofv", nfv - b_fv, 0);
    check("resume_number", number, 0);
    mark;
    scan(4, 3, 2, 1, 6);
    check("post_rst_count", nfv - b_fv, 1);
    check("post_rst_number", number, 4321);
    check("post_rst_score", score, 6);
`ifdef SSD_CAPTURE_STATS_EN
    check("post_rst_fcount", frame_count, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
